// File: rtl/matvec_mac_engine.sv
// matvec_mac_engine
//   Matrix-vector multiply: Cout[r] = sum_k A[r][k] * B[k], r < ROWS, k < DEPTH.
//   Each accepted beat carries one column of A (all ROWS lanes) plus B[k].
//   ROWS MAC lanes work in parallel through a two-stage pipeline:
//     stage 1 registers the lane products, stage 2 accumulates them.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   Clr        synchronous clear: abort pass, zero accumulators, return to IDLE
//   in_valid   input beat valid; a beat is taken when in_valid & in_ready
//   in_ready   engine can take a beat (IDLE/ACCUM and no Clr)
//   in_a       column k of A, lane r at [r*DATA_W +: DATA_W]
//   in_b       B[k]
//   in_last    producer's end-of-pass marker
//   out_valid  Cout holds a complete result
//   out_ready  consumer takes the result
//   Cout       results, lane r at [r*ACC_W +: ACC_W]
//   err_len    sticky flag: in_last disagreed with the beat count
//
// Build option
//   MATVEC_SAT_EN  when defined, each lane saturates on accumulate overflow
//                  instead of wrapping modulo 2^ACC_W.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for the first beat of a pass
// S_ACCUM | beats 2..DEPTH of the pass being taken
// S_DRAIN | last product moving through the accumulate stage
// S_DONE  | result presented, held until out_valid & out_ready

module matvec_mac_engine #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ROWS   = 8,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROWS*ACC_W-1:0]    Cout,
  output logic                     err_len
);

  localparam int CNT_W = $clog2(DEPTH);
  localparam int PW    = 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_out_valid;
  logic                    r_err_len;
  logic                    r_p_valid;
  logic                    r_p_first;
  logic [ROWS*PW-1:0]      r_prod;
  logic [ROWS*ACC_W-1:0]   r_acc;

  logic                    w_accept;
  logic                    w_last_beat;
  logic [ROWS*PW-1:0]      w_prod;
  logic [ROWS*ACC_W-1:0]   w_acc_nxt;

  assign in_ready    = ((r_state == S_IDLE) || (r_state == S_ACCUM)) && !Clr;
  assign w_accept    = in_valid && in_ready;
  assign w_last_beat = (r_cnt == CNT_W'(DEPTH - 1));

  assign out_valid = r_out_valid;
  assign err_len   = r_err_len;
  assign Cout      = r_acc;

  for (genvar g = 0; g < ROWS; g++) begin : g_lane
    logic [ACC_W-1:0] w_a;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_add;

    assign w_a = r_acc[g*ACC_W +: ACC_W];

    if (SIGNED != 0) begin : g_sgn
      logic signed [PW-1:0]    w_sa;
      logic signed [PW-1:0]    w_sb;
      logic signed [ACC_W-1:0] w_se;
      assign w_sa = PW'($signed(in_a[g*DATA_W +: DATA_W]));
      assign w_sb = PW'($signed(in_b));
      assign w_prod[g*PW +: PW] = w_sa * w_sb;
      assign w_se  = ACC_W'($signed(r_prod[g*PW +: PW]));
      assign w_ext = w_se;
    end else begin : g_uns
      assign w_prod[g*PW +: PW] = PW'(in_a[g*DATA_W +: DATA_W]) * PW'(in_b);
      assign w_ext = ACC_W'(r_prod[g*PW +: PW]);
    end

`ifdef MATVEC_SAT_EN
    if (SIGNED != 0) begin : g_sat_s
      logic [ACC_W-1:0] w_sum;
      logic             w_ovf;
      assign w_sum = w_a + w_ext;
      // Overflow only when both operands share a sign and the sum flips it.
      assign w_ovf = (w_a[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != w_a[ACC_W-1]);
      assign w_add = !w_ovf ? w_sum :
                     w_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin : g_sat_u
      logic [ACC_W:0] w_sum;
      assign w_sum = {1'b0, w_a} + {1'b0, w_ext};
      assign w_add = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    end
`else
    assign w_add = w_a + w_ext;
`endif

    // First product of a pass replaces whatever the previous pass left behind.
    assign w_acc_nxt[g*ACC_W +: ACC_W] = r_p_first ? w_ext : w_add;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_err_len   <= 1'b0;
    end else if (Clr) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            // Length error is flagged but the pass always runs DEPTH beats.
            r_err_len <= r_err_len | (in_last != w_last_beat);
            if (w_last_beat) begin
              r_cnt   <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= S_ACCUM;
            end
          end
        end
        S_DRAIN: begin
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_valid <= 1'b0;
      r_p_first <= 1'b0;
      r_prod    <= '0;
      r_acc     <= '0;
    end else if (Clr) begin
      r_p_valid <= 1'b0;
      r_p_first <= 1'b0;
      r_prod    <= '0;
      r_acc     <= '0;
    end else begin
      r_p_valid <= w_accept;
      if (w_accept) begin
        r_prod    <= w_prod;
        r_p_first <= (r_cnt == '0);
      end
      if (r_p_valid) begin
        r_acc <= w_acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_matvec_mac_engine.sv
`timescale 1ns/1ps
module tb_matvec_mac_engine;
  localparam int DW = 8, DEPTH = 8, ROWS = 8, AW = 24, AW16 = 16;

  logic clk = 1'b0, rst_n = 1'b0, Clr = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [ROWS*DW-1:0] in_a = '0;
  logic [DW-1:0]      in_b = '0;

  logic in_ready, out_valid, err_len;
  logic [ROWS*AW-1:0] Cout;
  logic in_ready16, out_valid16, err_len16;
  logic [ROWS*AW16-1:0] Cout16;

  int n_vec = 0, n_err = 0, n_acc = 0;
  logic [ROWS*AW-1:0]   q24[$];
  logic [ROWS*AW16-1:0] q16[$];

  always #5 clk = ~clk;

  matvec_mac_engine #(.DATA_W(DW), .DEPTH(DEPTH), .ROWS(ROWS), .ACC_W(AW), .SIGNED(0)) dut (
    .clk(clk), .rst_n(rst_n), .Clr(Clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .Cout(Cout), .err_len(err_len));

  matvec_mac_engine #(.DATA_W(DW), .DEPTH(DEPTH), .ROWS(ROWS), .ACC_W(AW16), .SIGNED(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .Clr(Clr), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid16),
    .out_ready(out_ready), .Cout(Cout16), .err_len(err_len16));

  always @(posedge clk) if (in_valid && in_ready) n_acc <= n_acc + 1;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare whenever a result handshake is presented.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chki("q24_has_entry", q24.size(), (q24.size() > 0) ? q24.size() : 1);
      if (q24.size() > 0) chk("Cout24", 192'(Cout), 192'(q24.pop_front()));
    end
    if (rst_n && out_valid16 && out_ready) begin
      chki("q16_has_entry", q16.size(), (q16.size() > 0) ? q16.size() : 1);
      if (q16.size() > 0) chk("Cout16", 192'(Cout16), 192'(q16.pop_front()));
    end
  end

  function automatic logic [ROWS*DW-1:0] a_vec(input int base, input int step);
    logic [ROWS*DW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = DW'(base + step * r);
    return v;
  endfunction

  function automatic logic [ROWS*AW-1:0] exp24(input int base, input int step);
    logic [ROWS*AW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*AW +: AW] = AW'(base + step * r);
    return v;
  endfunction

  function automatic logic [ROWS*AW16-1:0] exp16(input int base, input int step);
    logic [ROWS*AW16-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*AW16 +: AW16] = AW16'(base + step * r);
    return v;
  endfunction

  // Present one beat and hold it until the engine takes it.
  task automatic beat(input logic [ROWS*DW-1:0] a, input logic [DW-1:0] b, input logic last);
    logic ok;
    int   g;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    ok = 1'b0; g = 0;
    while (!ok && g < 40) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      g++;
    end
    if (!ok) chkb("beat_accept_timeout", ok, 1'b1);
  endtask

  task automatic pass(input logic [ROWS*DW-1:0] a, input int b0, input int bstep,
                      input int last_pos, input bit gap);
    for (int k = 0; k < DEPTH; k++) begin
      beat(a, DW'(b0 + bstep * k), (k == last_pos));
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for a result (monitor compares it), then step past the edge.
  task automatic wait_out();
    int g;
    g = 0;
    while (g < 20) begin
      @(negedge clk);
      if (out_valid) break;
      g++;
    end
    if (g >= 20) chkb("out_valid_timeout", out_valid, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    // 1: reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chkb("rst_out_valid", out_valid, 1'b0);
    chk ("rst_Cout", 192'(Cout), '0);
    chkb("rst_err_len", err_len, 1'b0);
    chkb("rst_in_ready", in_ready, 1'b1);
    chkb("rst_in_ready16", in_ready16, 1'b1);
    @(posedge clk); #1;

    // 2: A all 1, B = 1..8 back-to-back, checks 2-cycle latency
    q24.push_back(exp24(36, 0));
    q16.push_back(exp16(36, 0));
    pass(a_vec(1, 0), 1, 1, DEPTH - 1, 1'b0);
    @(negedge clk);
    chkb("lat_cycle1_out_valid", out_valid, 1'b0);
    @(negedge clk);
    chkb("lat_cycle2_out_valid", out_valid, 1'b1);
    chkb("t2_err_len", err_len, 1'b0);
    @(posedge clk); #1;

    // 3: same data, in_valid toggled every other cycle
    n0 = n_acc;
    q24.push_back(exp24(36, 0));
    q16.push_back(exp16(36, 0));
    pass(a_vec(1, 0), 1, 1, DEPTH - 1, 1'b1);
    wait_out();
    chki("t3_beats_accepted", n_acc - n0, DEPTH);

    // 4: consumer stalls 5 cycles in DONE, extra beat offered meanwhile
    out_ready = 1'b0;
    q24.push_back(exp24(36, 0));
    q16.push_back(exp16(36, 0));
    pass(a_vec(1, 0), 1, 1, DEPTH - 1, 1'b0);
    wait_out();
    n0 = n_acc;
    in_a = a_vec(99, 3); in_b = 8'd77; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chkb("t4_in_ready_done", in_ready, 1'b0);
      chkb("t4_out_valid_held", out_valid, 1'b1);
      chk ("t4_Cout_stable", 192'(Cout), 192'(exp24(36, 0)));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chki("t4_no_beat_in_done", n_acc - n0, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chkb("t4_in_ready_after_hs", in_ready, 1'b1);
    chkb("t4_out_valid_after_hs", out_valid, 1'b0);
    @(posedge clk); #1;
    q24.push_back(exp24(8, 8));
    q16.push_back(exp16(8, 8));
    pass(a_vec(1, 1), 1, 0, DEPTH - 1, 1'b0);
    wait_out();

    // 5: Clr after 4 beats, beat presented with Clr is dropped
    n0 = n_acc;
    for (int k = 0; k < 4; k++) beat(a_vec(1, 0), DW'(k + 1), 1'b0);
    Clr = 1'b1; in_a = a_vec(1, 0); in_b = 8'd5; in_valid = 1'b1;
    @(negedge clk);
    chkb("t5_in_ready_clr", in_ready, 1'b0);
    @(posedge clk); #1;
    Clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chki("t5_beats_before_clr", n_acc - n0, 4);
    chkb("t5_out_valid", out_valid, 1'b0);
    chk ("t5_Cout_cleared", 192'(Cout), '0);
    @(negedge clk);
    chk ("t5_Cout_flushed", 192'(Cout), '0);
    chkb("t5_in_ready_idle", in_ready, 1'b1);
    @(posedge clk); #1;
    q24.push_back(exp24(0, 16));
    q16.push_back(exp16(0, 16));
    pass(a_vec(0, 1), 2, 0, DEPTH - 1, 1'b0);
    wait_out();

    // 6: A = B = 255, in_last on beat 5: wrap/saturate and length error
    q24.push_back(exp24(520200, 0));
`ifdef MATVEC_SAT_EN
    q16.push_back(exp16(65535, 0));
`else
    q16.push_back(exp16(61448, 0));
`endif
    pass(a_vec(255, 0), 255, 0, 4, 1'b0);
    wait_out();
    chkb("t6_err_len", err_len, 1'b1);
    chkb("t6_err_len16", err_len16, 1'b1);
    Clr = 1'b1;
    @(posedge clk); #1;
    Clr = 1'b0;
    @(negedge clk);
    chkb("t6_err_len_clr", err_len, 1'b0);
    chkb("t6_err_len16_clr", err_len16, 1'b0);

    @(posedge clk); #1;
    chki("q24_drained", q24.size(), 0);
    chki("q16_drained", q16.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
